// File: rtl/sec32_pkg.sv
// sec32_pkg: shared constants, check-bit masks and codeword type for the 32-bit SEC code.
package sec32_pkg;
    localparam int DATA_W = 32;
    localparam int CHK_W = 8;
    localparam logic [DATA_W-1:0] CHK_MASK [CHK_W] = '{
        32'h00FF1111,
        32'hFF002222,
        32'h0F0F4444,
        32'hF0F08888,
        32'h111100FF,
        32'h2222FF00,
        32'h4444FFFF,
        32'h8888F0F0
    };
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CHK_W-1:0]  check;
        logic              chk_en;
    } codeword_t;
endpackage

// File: rtl/sec32_parity_gen.sv
// sec32_parity_gen: combinational even-parity check bits for 32 data bits.
module sec32_parity_gen
    import sec32_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    output logic [CHK_W-1:0]  o_check
);
    always_comb begin
        o_check = '0;
        for (int i = 0; i < CHK_W; i++) o_check[i] = ^(i_data & CHK_MASK[i]);
    end
endmodule

// File: rtl/sec32_encoder_pipe.sv
// sec32_encoder_pipe: valid/ready SEC(32) encoder, 1- or 2-stage pipeline, delivered-word counter.
// Optional single-bit error injection at the output register when SEC32_ERR_INJECT_EN is defined.
module sec32_encoder_pipe
    import sec32_pkg::*;
#(
    parameter int PIPE_STAGES = 2,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_chk_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CHK_W-1:0]  out_check,
    output logic              out_chk_en,
    output logic [CNT_W-1:0]  word_cnt
`ifdef SEC32_ERR_INJECT_EN
    ,
    input  logic              inj_arm,
    input  logic [5:0]        inj_pos,
    output logic              inj_done
`endif
);
    logic r_out_v;
    codeword_t r_out;
    codeword_t w_next;
    logic w_next_v;
    logic w_out_ld;
    logic w_out_hs;
    logic [CNT_W-1:0] r_cnt;
    logic [DATA_W+CHK_W-1:0] w_flip;

    assign w_out_ld = ~r_out_v | out_ready;
    assign w_out_hs = r_out_v & out_ready;

    generate
        if (PIPE_STAGES == 1) begin : g_one
            logic [CHK_W-1:0] w_chk;
            sec32_parity_gen u_gen (.i_data(in_data), .o_check(w_chk));
            assign in_ready = w_out_ld;
            assign w_next_v = in_valid;
            assign w_next = {in_data, w_chk, in_chk_en};
        end else begin : g_two
            logic r_s1_v;
            logic [DATA_W-1:0] r_s1_data;
            logic r_s1_tag;
            logic [3:0][CHK_W-1:0] w_part;
            logic [3:0][CHK_W-1:0] r_part;
            // per-byte partial parities; stage 2 folds the four groups
            for (genvar g = 0; g < 4; g++) begin : g_grp
                sec32_parity_gen u_gen (
                    .i_data(in_data & (DATA_W'(8'hFF) << (8 * g))),
                    .o_check(w_part[g])
                );
            end
            assign in_ready = ~r_s1_v | w_out_ld;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_s1_v <= 1'b0;
                else if (in_ready) r_s1_v <= in_valid;
            end
            always_ff @(posedge clk) begin
                if (in_valid && in_ready) begin
                    r_s1_data <= in_data;
                    r_s1_tag  <= in_chk_en;
                    r_part    <= w_part;
                end
            end
            assign w_next_v = r_s1_v;
            assign w_next = {r_s1_data, r_part[0] ^ r_part[1] ^ r_part[2] ^ r_part[3], r_s1_tag};
        end
    endgenerate

`ifdef SEC32_ERR_INJECT_EN
    logic r_armed;
    logic r_out_inj;
    logic r_done;
    logic [5:0] r_pos;
    logic w_inj_ld;
    // a corrupted word still waiting in the output register blocks a second flip
    assign w_inj_ld = r_armed & ~(r_out_v & r_out_inj);
    assign w_flip = (w_inj_ld && r_pos < 6'd40) ? (DATA_W + CHK_W)'(1) << r_pos : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed   <= 1'b0;
            r_out_inj <= 1'b0;
            r_done    <= 1'b0;
            r_pos     <= '0;
        end else begin
            r_done <= w_out_hs & r_out_inj;
            if (inj_arm) begin
                r_armed <= 1'b1;
                r_pos   <= inj_pos;
            end else if (w_out_hs && r_out_inj) begin
                r_armed <= 1'b0;
            end
            if (w_out_ld) r_out_inj <= w_next_v & w_inj_ld;
        end
    end
    assign inj_done = r_done;
`else
    assign w_flip = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_v <= 1'b0;
            r_out   <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_out_ld) r_out_v <= w_next_v;
            if (w_out_ld && w_next_v) r_out <= w_next ^ {w_flip[DATA_W-1:0], w_flip[DATA_W+CHK_W-1:DATA_W], 1'b0};
            if (w_out_hs) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out_valid  = r_out_v;
    assign out_data   = r_out.data;
    assign out_check  = r_out.check;
    assign out_chk_en = r_out.chk_en;
    assign word_cnt   = r_cnt;
endmodule

// File: tb/tb_sec32_encoder_pipe.sv
// tb_sec32_encoder_pipe: directed self-checking bench for the SEC(32) encoder pipeline.
module tb_sec32_encoder_pipe;
    import sec32_pkg::*;

    localparam int N = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, in_ready, in_chk_en = 1'b0;
    logic [31:0] in_data = '0;
    logic out_valid, out_ready = 1'b0, out_chk_en;
    logic [31:0] out_data;
    logic [7:0] out_check;
    logic [15:0] word_cnt;

    logic b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_out_chk_en;
    logic [31:0] b_in_data = '0, b_out_data;
    logic [7:0] b_out_check;
    logic [3:0] b_word_cnt;

    logic [7:0] ref_chk;
    int n_assert = 0;
    int n_fail = 0;
    logic [31:0] last_data;
    logic [7:0] last_check;

`ifdef SEC32_ERR_INJECT_EN
    logic inj_arm = 1'b0, inj_done, b_inj_done;
    logic [5:0] inj_pos = '0;
`endif

    always #5 clk = ~clk;

    sec32_encoder_pipe #(.PIPE_STAGES(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_chk_en(in_chk_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_check(out_check), .out_chk_en(out_chk_en), .word_cnt(word_cnt)
`ifdef SEC32_ERR_INJECT_EN
        , .inj_arm(inj_arm), .inj_pos(inj_pos), .inj_done(inj_done)
`endif
    );

    sec32_encoder_pipe #(.PIPE_STAGES(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_chk_en(1'b0),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_check(b_out_check), .out_chk_en(b_out_chk_en), .word_cnt(b_word_cnt)
`ifdef SEC32_ERR_INJECT_EN
        , .inj_arm(1'b0), .inj_pos(6'd0), .inj_done(b_inj_done)
`endif
    );

    sec32_parity_gen u_ref (.i_data(in_data), .o_check(ref_chk));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] correct(input logic [31:0] d, input logic [7:0] c);
        logic [7:0] s, col;
        logic [31:0] r;
        r = d;
        for (int i = 0; i < 8; i++) s[i] = (^(d & CHK_MASK[i])) ^ c[i];
        for (int j = 0; j < 32; j++) begin
            for (int i = 0; i < 8; i++) col[i] = CHK_MASK[i][j];
            if (s != 0 && col == s) r[j] = ~r[j];
        end
        return r;
    endfunction

    task automatic push(input logic [31:0] d, input logic t);
        in_valid = 1'b1;
        in_data = d;
        in_chk_en = t;
        for (int i = 0; i < 50 && !in_ready; i++) begin
            @(posedge clk);
            #1;
        end
        check("push_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [31:0] ed, input logic [7:0] ec, input logic et);
        out_ready = 1'b1;
        for (int i = 0; i < 50 && !out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, out_data, ed);
        check({tag, "_check"}, out_check, ec);
        check({tag, "_tag"}, out_chk_en, et);
        last_data = out_data;
        last_check = out_check;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [40:0] exp_q[$];
        logic [40:0] cw, prev_cw;
        logic prev_stall, hs_in;
        int sent, recv;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_check", out_check, 0);
        check("rst_out_chk_en", out_chk_en, 0);
        check("rst_word_cnt", word_cnt, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);

        in_valid = 1'b1;
        in_data = 32'h0;
        in_chk_en = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("lat_cycle1_valid", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_cycle2_valid", out_valid, 1);
        check("lat_check", out_check, 8'h00);
        check("lat_chk_en", out_chk_en, 1);
        @(posedge clk);
        #1;
        check("hold_valid", out_valid, 1);
        check("hold_chk_en", out_chk_en, 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("lat_drained", out_valid, 0);
        check("lat_word_cnt", word_cnt, 1);

        push(32'h00000001, 1'b0);
        pop("d_lsb", 32'h00000001, 8'h51, 1'b0);
        push(32'h80000000, 1'b1);
        pop("d_msb", 32'h80000000, 8'h8A, 1'b1);
        push(32'hFFFFFFFF, 1'b0);
        pop("d_ones", 32'hFFFFFFFF, 8'h00, 1'b0);
        check("directed_word_cnt", word_cnt, 4);

        sent = 0;
        recv = 0;
        prev_stall = 1'b0;
        prev_cw = '0;
        in_valid = 1'b1;
        in_data = $urandom;
        in_chk_en = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 3000 && recv < N; cyc++) begin
            @(negedge clk);
            cw = {out_data, out_check, out_chk_en};
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_payload", cw, prev_cw);
            end
            hs_in = in_valid & in_ready;
            if (hs_in) begin
                exp_q.push_back({in_data, ref_chk, in_chk_en});
                sent++;
            end
            if (out_valid && out_ready) begin
                check("stream_q_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("stream_word", cw, exp_q.pop_front());
                check("stream_decode", correct(out_data, out_check), out_data);
                recv++;
            end
            prev_stall = out_valid & ~out_ready;
            prev_cw = cw;
            @(posedge clk);
            #1;
            if (hs_in) begin
                in_valid = (sent < N);
                in_data = $urandom;
                in_chk_en = 1'($urandom_range(0, 1));
            end
            out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("stream_recv", recv, N);
        check("stream_leftover", exp_q.size(), 0);
        check("stream_word_cnt", word_cnt, 4 + N);

        push(32'h12345678, 1'b1);
        push(32'h9ABCDEF0, 1'b0);
        check("inflight_valid", out_valid, 1);
        check("inflight_full", in_ready, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_cnt", word_cnt, 0);
        check("async_rst_data", out_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_no_stale", out_valid, 0);
        end
        out_ready = 1'b0;
        check("post_rst_cnt", word_cnt, 0);

        b_out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            b_in_valid = 1'b1;
            b_in_data = 32'(i + 1);
            @(posedge clk);
            #1;
            if (i == 0) begin
                check("b_lat1_valid", b_out_valid, 1);
                check("b_lat1_data", b_out_data, 1);
                check("b_lat1_check", b_out_check, 8'h51);
            end
        end
        b_in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("b_wrap_cnt", b_word_cnt, 1);
        check("b_drained", b_out_valid, 0);

`ifdef SEC32_ERR_INJECT_EN
        inj_pos = 6'd5;
        inj_arm = 1'b1;
        @(posedge clk);
        #1;
        inj_arm = 1'b0;
        push(32'h0, 1'b1);
        pop("inj5", 32'h00000020, 8'h00, 1'b1);
        check("inj5_done", inj_done, 1);
        check("inj5_corrected", correct(last_data, last_check), 32'h0);
        @(posedge clk);
        #1;
        check("inj5_done_pulse", inj_done, 0);
        push(32'h0, 1'b0);
        pop("inj_disarmed", 32'h0, 8'h00, 1'b0);
        check("inj_disarmed_done", inj_done, 0);

        inj_pos = 6'd33;
        inj_arm = 1'b1;
        @(posedge clk);
        #1;
        inj_arm = 1'b0;
        push(32'h0, 1'b0);
        pop("inj33", 32'h0, 8'h02, 1'b0);
        check("inj33_done", inj_done, 1);

        inj_pos = 6'd50;
        inj_arm = 1'b1;
        @(posedge clk);
        #1;
        inj_arm = 1'b0;
        push(32'h00000001, 1'b1);
        pop("inj50", 32'h00000001, 8'h51, 1'b1);
        check("inj50_done", inj_done, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
